// File: rtl/layer_serializer.sv
// Serializes an NN-word parallel layer result into one word per cycle.
// A single pending buffer absorbs one frame that arrives while another is streaming.
module layer_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    mismatch,
  input  logic                    clr_err
);

  localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned FW = NN * dataWidth;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          active_q, active_d;
  logic [FW-1:0]          pending_q, pending_d;
  logic                   pend_full_q, pend_full_d;
  logic                   o_valid_q, o_valid_d;
  logic [dataWidth-1:0]   o_data_q, o_data_d;
  logic                   o_last_q, o_last_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   mismatch_q, mismatch_d;
  logic                   start;
  logic                   ov_set;
  logic                   mm_set;

  // Next-state, buffer steering and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    ov_set      = 1'b0;
    start       = i_valid[0];
    mm_set      = (i_valid != '0) && (i_valid != '1);

    if (state_q == IDLE) begin
      if (start) begin
        active_d = i_data;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
    end else if (cnt_q == LAST_BEAT) begin
      cnt_d = '0;
      if (pend_full_q) begin
        active_d = pending_q;
        if (start) begin
          pending_d = i_data;
        end else begin
          pend_full_d = 1'b0;
        end
      end else if (start) begin
        active_d = i_data;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (start) begin
        if (!pend_full_q) begin
          pending_d   = i_data;
          pend_full_d = 1'b1;
        end else begin
          ov_set = 1'b1;
        end
      end
    end

    overrun_d  = ov_set | (overrun_q & ~clr_err);
    mismatch_d = mm_set | (mismatch_q & ~clr_err);

    o_valid_d = (state_d == SHIFT);
    o_data_d  = o_valid_d ? active_d[int'(cnt_d) * dataWidth +: dataWidth] : '0;
    o_last_d  = o_valid_d && (cnt_d == LAST_BEAT);
    busy_d    = o_valid_d | pend_full_d;
  end

  // Frame buffers carry no reset; their contents are never visible while idle
  always_ff @(posedge clk) begin
    active_q  <= active_d;
    pending_q <= pending_d;
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_last_q    <= o_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_last   = o_last_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer (NN=4, 16-bit words): hand vector table, directed
// multi-cycle sequences and a randomized run against a frame-queue model.
module tb_layer_serializer;

  localparam int unsigned NN = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NN-1:0] i_valid;
  logic [63:0]   i_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          busy;
  logic          overrun;
  logic          mismatch;
  logic          clr_err;

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .busy(busy),
    .overrun(overrun), .mismatch(mismatch), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the frame currently on the wire, its word index, and waiting frames
  logic [63:0] m_cur;
  int          m_idx;
  logic [63:0] m_pend[$];
  logic        m_ov;
  logic        m_mm;

  typedef struct {
    logic        r;
    logic [3:0]  iv;
    logic [63:0] d;
    logic        c;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        eb;
    logic        eo;
    logic        em;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] iv, input logic [63:0] d,
                            input logic c);
    logic ov_set;
    if (r) begin
      m_idx = -1;
      m_pend.delete();
      m_ov  = 1'b0;
      m_mm  = 1'b0;
      return;
    end
    ov_set = 1'b0;
    if (m_idx >= 0) begin
      m_idx++;
      if (m_idx == NN) begin
        if (m_pend.size() > 0) begin
          m_cur = m_pend.pop_front();
          m_idx = 0;
        end else begin
          m_idx = -1;
        end
      end
    end
    if (iv[0]) begin
      if (m_idx < 0) begin
        m_cur = d;
        m_idx = 0;
      end else if (m_pend.size() == 0) begin
        m_pend.push_back(d);
      end else begin
        ov_set = 1'b1;
      end
    end
    m_ov = ov_set | (m_ov & ~c);
    m_mm = ((iv != 4'h0) && (iv != 4'hF)) | (m_mm & ~c);
  endtask

  task automatic step(input logic r, input logic [3:0] iv, input logic [63:0] d, input logic c);
    rst = r; i_valid = iv; i_data = d; clr_err = c;
    @(posedge clk);
    model_edge(r, iv, d, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [15:0] ed;
    ev = (m_idx >= 0);
    ed = ev ? m_cur[m_idx*16 +: 16] : 16'h0;
    chk({tag, ".o_valid"},  64'(o_valid),  64'(ev));
    chk({tag, ".o_data"},   64'(o_data),   64'(ed));
    chk({tag, ".o_last"},   64'(o_last),   64'(m_idx == NN - 1));
    chk({tag, ".busy"},     64'(busy),     64'(ev || (m_pend.size() > 0)));
    chk({tag, ".overrun"},  64'(overrun),  64'(m_ov));
    chk({tag, ".mismatch"}, 64'(mismatch), 64'(m_mm));
  endtask

  function automatic logic [63:0] frm(input logic [15:0] base);
    return {base + 16'h3, base + 16'h2, base + 16'h1, base};
  endfunction

  initial begin
    int beats;
    int lasts;
    logic [3:0] iv;

    m_idx = -1; m_cur = '0; m_ov = 1'b0; m_mm = 1'b0;
    rst = 1'b1; i_valid = '0; i_data = '0; clr_err = 1'b0;

    // Hand-derived vectors: reset, single frame, mismatch with clear, set-beats-clear
    tbl.push_back('{1'b1, 4'h0, 64'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 64'h0044_0033_0022_0011, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 16'h0044, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h3, 64'h00A4_00A3_00A2_00A1, 1'b0, 1'b1, 16'h00A1, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 16'h00A2, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 16'h00A4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'h4, 64'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d.o_valid", i),  64'(o_valid),  64'(tbl[i].ev));
      chk($sformatf("tbl%0d.o_data", i),   64'(o_data),   64'(tbl[i].ed));
      chk($sformatf("tbl%0d.o_last", i),   64'(o_last),   64'(tbl[i].el));
      chk($sformatf("tbl%0d.busy", i),     64'(busy),     64'(tbl[i].eb));
      chk($sformatf("tbl%0d.overrun", i),  64'(overrun),  64'(tbl[i].eo));
      chk($sformatf("tbl%0d.mismatch", i), 64'(mismatch), 64'(tbl[i].em));
    end

    // Back-to-back: frame A at T, frame B at T+2 -> 8 contiguous beats
    step(1'b1, 4'h0, 64'h0, 1'b0);
    beats = 0; lasts = 0;
    for (int i = 0; i < 8; i++) begin
      iv = (i == 0 || i == 2) ? 4'hF : 4'h0;
      step(1'b0, iv, (i == 0) ? frm(16'h1000) : frm(16'h2000), 1'b0);
      check_model($sformatf("b2b%0d", i));
      chk($sformatf("b2b%0d.busy_hi", i), 64'(busy), 64'(1));
      beats += int'(o_valid);
      lasts += int'(o_last);
    end
    chk("b2b.beats", 64'(beats), 64'(8));
    chk("b2b.lasts", 64'(lasts), 64'(2));
    step(1'b0, 4'h0, 64'h0, 1'b0);
    check_model("b2b.end");

    // Overrun: frames at T, T+1, T+2; third dropped, flag sticky until cleared
    step(1'b1, 4'h0, 64'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      iv = (i < 3) ? 4'hF : 4'h0;
      step(1'b0, iv, frm(16'h3000 + 16'(i) * 16'h100), 1'b0);
      check_model($sformatf("ovr%0d", i));
    end
    chk("ovr.held", 64'(overrun), 64'(1));
    step(1'b0, 4'h0, 64'h0, 1'b1);
    chk("ovr.cleared", 64'(overrun), 64'(0));

    // Start on A's final beat: B follows with no gap, nothing left pending
    step(1'b1, 4'h0, 64'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iv = (i == 0 || i == 4) ? 4'hF : 4'h0;
      step(1'b0, iv, (i == 0) ? frm(16'h4000) : frm(16'h5000), 1'b0);
      check_model($sformatf("fin%0d", i));
      if (i == 4) chk("fin.b_word0", 64'(o_data), 64'(16'h5000));
    end
    chk("fin.idle_after", 64'(busy), 64'(0));

    // Reset mid-frame, with a start in the reset cycle that must be ignored
    step(1'b1, 4'h0, 64'h0, 1'b0);
    step(1'b0, 4'hF, frm(16'h6000), 1'b0);
    step(1'b0, 4'h0, 64'h0, 1'b0);
    step(1'b1, 4'hF, frm(16'h7000), 1'b0);
    chk("rstmid.o_valid", 64'(o_valid), 64'(0));
    chk("rstmid.busy", 64'(busy), 64'(0));
    step(1'b0, 4'h0, 64'h0, 1'b0);
    check_model("rstmid.t4");
    step(1'b0, 4'h0, 64'h0, 1'b0);
    check_model("rstmid.t5");
    step(1'b0, 4'hF, frm(16'h8000), 1'b0);
    chk("rstmid.word0", 64'(o_data), 64'(16'h8000));
    check_model("rstmid.t6");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 45)      iv = 4'h0;
      else if (sel < 85) iv = 4'hF;
      else               iv = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) < 2), iv, {$urandom, $urandom},
           ($urandom_range(0, 99) < 8));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NN, default 30: number of parallel neuron results per frame (NN >= 2).
REQ-002 Parameter dataWidth, default 16: width of one neuron result.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset is synchronous and active-high.
REQ-005 Port i_valid, input, NN: per-neuron output-valid strobes from the preceding layer.
REQ-006 Port i_data, input, NN*dataWidth: packed neuron results, word k at bits [k*dataWidth +: dataWidth].
REQ-007 Port o_valid, output, 1: serial word valid, feeds next layer x_valid.
REQ-008 Port o_data, output, dataWidth: serial word, feeds next layer x_in.
REQ-009 Port o_last, output, 1: high with the final word (index NN-1) of a frame.
REQ-010 Port busy, output, 1: high while in SHIFT or pending buffer full.
REQ-011 Port overrun, output, 1: sticky, frame dropped.
REQ-012 Port mismatch, output, 1: sticky, i_valid neither all-zero nor all-one.
REQ-013 Port clr_err, input, 1: clears overrun and mismatch.

Function
REQ-014 Frame start condition: i_valid[0] sampled high; other bits are not used for capture.
REQ-015 Two buffers, each NN x dataWidth: active (being shifted) and pending (one waiting frame), plus pend_full flag.
REQ-016 States: IDLE, SHIFT; beat counter cnt, width $clog2(NN), range 0..NN-1, no wrap beyond NN-1.
REQ-017 IDLE + start at edge T: i_data to active, cnt=0, go SHIFT; o_valid=1 with word 0 at T+1.
REQ-018 SHIFT: one word per cycle, index order 0..NN-1; o_data = active[cnt]; o_valid=1 every SHIFT cycle, no gaps.
REQ-019 Latency: word k of a frame captured at edge T appears in cycle T+1+k; o_last=1 only when cnt==NN-1.
REQ-020 Final beat (cnt==NN-1), pend_full=0, no start: next state IDLE, o_valid=0.
REQ-021 Final beat, pend_full=1: pending to active, pend_full=0, cnt=0, stay SHIFT (contiguous frames).
REQ-022 Final beat, pend_full=0, start high: i_data directly to active, cnt=0, stay SHIFT.
REQ-023 Final beat, pend_full=1, start high: pending to active, i_data to pending, pend_full stays 1; no overrun.
REQ-024 SHIFT non-final beat, start high, pend_full=0: i_data to pending, pend_full=1.
REQ-025 SHIFT non-final beat, start high, pend_full=1: new frame dropped, pending unchanged, overrun=1 next cycle.
REQ-026 mismatch set one cycle after any edge where i_valid != 0 and i_valid != all-ones; capture still follows REQ-014.
REQ-027 clr_err high: overrun and mismatch cleared next cycle; a simultaneous set condition wins (flag stays/becomes 1).
REQ-028 o_data = 0 whenever o_valid=0.
REQ-029 busy = (state==SHIFT) | pend_full, registered-state derived, no combinational path from i_valid.

Reset
REQ-030 rst high at an edge: state IDLE, cnt=0, pend_full=0, o_valid=0, o_last=0, o_data=0, busy=0, overrun=0, mismatch=0.
REQ-031 Buffer contents need not be cleared on reset; not observable since o_data gated by REQ-028.
REQ-032 rst mid-frame: remaining words abandoned, pending frame discarded, o_valid=0 from the following cycle; start in same cycle as rst ignored.

Verification (NN=4, dataWidth=16)
REQ-033 Single frame: i_valid=4'hF, i_data words {0x0011,0x0022,0x0033,0x0044} at T -> o_data 0x0011,0x0022,0x0033,0x0044 at T+1..T+4, o_last only at T+4, o_valid=0 at T+5.
REQ-034 Back-to-back: frame A at T, frame B at T+2 -> 8 contiguous valid beats T+1..T+8, A then B, o_last at T+4 and T+8, busy high T+1..T+8.
REQ-035 Overrun: frames at T, T+1, T+2 -> frames 1 and 2 streamed (8 beats), frame 3 dropped, overrun=1 from T+3 until clr_err.
REQ-036 Final-beat start: frame A at T, frame B at T+4 (A's last beat) -> B word 0 at T+5, no gap, pend_full stays 0.
REQ-037 Mismatch: i_valid=4'b0011 at T -> frame captured, mismatch=1 at T+1; clr_err at T+3 -> mismatch=0 at T+4.
REQ-038 Reset mid-frame: frame at T, rst at T+2 -> o_valid=0 from T+3, busy=0, next frame at T+5 streams from word 0 at T+6.
